// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read sprite ROM among NUM_REQ pixel-path requesters.
// Optional build macro SPRITE_ARB_PRIO0_EN: requester 0 gets strict priority, round-robin over 1..NUM_REQ-1.
module sprite_rom_arbiter #(
   parameter int unsigned       NUM_REQ     = 4,
   parameter int unsigned       ADDR_W      = 13,
   parameter int unsigned       DATA_W      = 8,
   parameter int unsigned       ROM_DEPTH   = 6580,
   parameter int unsigned       ROM_LATENCY = 1,
   parameter logic [DATA_W-1:0] TRANSPARENT = '0,
   localparam int unsigned      ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk_pix,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [DATA_W-1:0]         rom_data,
   output logic                      rsp_valid,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_err
);

   localparam int unsigned        SCAN_W  = ID_W + 1;
   localparam int unsigned        LAST    = ROM_LATENCY - 1;
   localparam logic [ADDR_W:0]    DEPTH_C = (ADDR_W + 1)'(ROM_DEPTH);
   localparam logic [SCAN_W-1:0]  NREQ_C  = SCAN_W'(NUM_REQ);
`ifdef SPRITE_ARB_PRIO0_EN
   localparam logic [ID_W-1:0]    PTR_RST = ID_W'(1);
`else
   localparam logic [ID_W-1:0]    PTR_RST = '0;
`endif

   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
      logic            err;
   } stage_t;

   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   stage_t            stg_q [ROM_LATENCY];
   stage_t            stage_in_c;

   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
   logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
   logic              rsp_err_q,   rsp_err_d;

   logic              win_c;
   logic [ID_W-1:0]   win_id_c;
   logic [SCAN_W-1:0] scan_c;
   logic              grant_c;
   logic [ADDR_W-1:0] sel_addr_c;
   logic              oor_c;

   // Winner search starting at rr_ptr, wrapping within the round-robin range
   always_comb begin
      win_c    = 1'b0;
      win_id_c = '0;
      scan_c   = '0;
`ifdef SPRITE_ARB_PRIO0_EN
      if (req[0]) begin
         win_c = 1'b1;
      end else begin
         for (int unsigned k = 0; k < NUM_REQ - 1; k++) begin
            scan_c = SCAN_W'(rr_ptr_q) + SCAN_W'(k);
            if (scan_c >= NREQ_C) scan_c = scan_c - (NREQ_C - SCAN_W'(1));
            if (!win_c && req[ID_W'(scan_c)]) begin
               win_c    = 1'b1;
               win_id_c = ID_W'(scan_c);
            end
         end
      end
`else
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_c = SCAN_W'(rr_ptr_q) + SCAN_W'(k);
         if (scan_c >= NREQ_C) scan_c = scan_c - NREQ_C;
         if (!win_c && req[ID_W'(scan_c)]) begin
            win_c    = 1'b1;
            win_id_c = ID_W'(scan_c);
         end
      end
`endif
   end

   // Grant, address mux and range check; nothing is granted while reset is held
   always_comb begin
      grant_c    = win_c & ~rst;
      sel_addr_c = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win_id_c == ID_W'(i)) sel_addr_c = req_addr[i*ADDR_W +: ADDR_W];
      end
      oor_c    = ({1'b0, sel_addr_c} >= DEPTH_C);
      gnt      = grant_c ? (NUM_REQ'(1) << win_id_c) : '0;
      rom_addr = (grant_c && !oor_c) ? sel_addr_c : '0;
   end

   // Pointer advance and pipeline/response next-state
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      stage_in_c  = '0;
      rsp_valid_d = stg_q[LAST].vld;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;

      if (grant_c) begin
         stage_in_c.vld = 1'b1;
         stage_in_c.id  = win_id_c;
         stage_in_c.err = oor_c;
`ifdef SPRITE_ARB_PRIO0_EN
         if (win_id_c != '0) begin
            rr_ptr_d = (win_id_c == ID_W'(NUM_REQ - 1)) ? ID_W'(1) : win_id_c + ID_W'(1);
         end
`else
         rr_ptr_d = (win_id_c == ID_W'(NUM_REQ - 1)) ? '0 : win_id_c + ID_W'(1);
`endif
      end

      if (stg_q[LAST].vld) begin
         rsp_id_d   = stg_q[LAST].id;
         rsp_err_d  = stg_q[LAST].err;
         rsp_data_d = stg_q[LAST].err ? TRANSPARENT : rom_data;
      end
   end

   // State registers; reset discards every in-flight read
   always_ff @(posedge clk_pix or posedge rst) begin
      if (rst) begin
         rr_ptr_q    <= PTR_RST;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         for (int unsigned i = 0; i < ROM_LATENCY; i++) stg_q[i] <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         stg_q[0]    <= stage_in_c;
         for (int unsigned i = 1; i < ROM_LATENCY; i++) stg_q[i] <= stg_q[i-1];
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

endmodule
